rx_s2mm_cmd_scheduler: RTL and testbench
========================================

# rx_s2mm_cmd_scheduler

Queues parsed RDMA WRITE headers and sequences them onto the single Data Mover S2MM command channel of the RDMA RX path. It sits between the header parser and the AXI DataMover and keeps up to MAX_OUTSTANDING commands in flight. Headers that arrive while earlier transfers are still pending are buffered, not dropped, and completions are tracked against issued commands. It filters opcodes, computes the fragment destination address and reports drops, rejects and completions.

## Interface
- C_ADDR_WIDTH, 32, DDR address width; fixed at 32 by the command format
- C_BTT_WIDTH, 23, bytes-to-transfer width
- OFFSET_LENGTH, 16, fragment offset width
- FIFO_DEPTH, 4, descriptor queue depth; power of two, at least 2
- MAX_OUTSTANDING, 2, maximum issued-but-uncompleted commands, 1..15
- RDMA_OPCODE_WRITE_FIRST/MIDDLE/LAST/ONLY/TEST, 8'h06/8'h07/8'h08/8'h0A/8'h01, accepted opcodes

Ports:
- aclk  in  1  clock; one clock domain
- areset  in  1  synchronous, active-high reset
- header_valid  in  1  one-cycle pulse; header fields valid in that cycle
- rdma_opcode  in  8  RDMA opcode
- rdma_remote_addr  in  64  base address; low 32 bits used
- rdma_length  in  32  payload bytes
- fragment_offset  in  OFFSET_LENGTH  byte offset added to the base
- m_axis_s2mm_cmd_tdata  out  72  DataMover command
- m_axis_s2mm_cmd_tvalid  out  1  command valid
- m_axis_s2mm_cmd_tready  in  1  command ready
- s2mm_wr_xfer_cmplt  in  1  one-cycle pulse per completed transfer
- write_accepted  out  1  pulse: header queued
- hdr_rejected  out  1  pulse: bad opcode, zero length or oversize
- hdr_dropped  out  1  pulse: valid header lost because the queue was full
- write_complete  out  1  pulse per matched completion
- cmplt_error  out  1  pulse: completion arrived with nothing outstanding
- outstanding  out  4  issued-but-uncompleted count
- fifo_level  out  clog2(FIFO_DEPTH)+1  queued descriptors
- drop_count  out  16  saturating count of hdr_dropped
- busy  out  1  high when fifo_level != 0, outstanding != 0, or state is ISSUE

## Operation
- Header admission happens in the header_valid cycle only:
  - opcode outside the accepted set, rdma_length == 0, or rdma_length > 2^C_BTT_WIDTH-1 -> hdr_rejected; nothing is queued.
  - otherwise, if not full or a pop occurs in the same cycle -> push {addr, btt} and pulse write_accepted.
  - otherwise -> hdr_dropped; drop_count increments and saturates at 16'hFFFF.
- Address = rdma_remote_addr[31:0] + zero-extended fragment_offset, mod 2^32, computed at push time. btt = rdma_length[22:0].
- FSM has two states:
  - IDLE: if fifo_level != 0 and outstanding < MAX_OUTSTANDING, pop the head, load the command register, go to ISSUE.
  - ISSUE: tvalid = 1 with tdata stable until tready. On tready, tag increments and outstanding increments. Go to IDLE.
- Command format is {4'b0000, tag[3:0], addr[31:0], 1'b0 type, 1'b1 DSA, 6'b0, 1'b1 EOF, btt[22:0]}. tag is a 4-bit issue counter that wraps 15 -> 0.
- Completion handling:
  - s2mm_wr_xfer_cmplt with outstanding > 0 -> outstanding decrements; write_complete pulses.
  - With outstanding == 0 -> cmplt_error pulses; the count is unchanged.
  - A handshake and a completion in the same cycle leave outstanding unchanged; write_complete still pulses.
- Completions are counted only, never matched to specific tags.

## Timing
- Reset values are 0 for every output: tvalid, tdata, all pulses, outstanding, fifo_level, drop_count and busy. State is IDLE and tag is 0.
- Asserting areset mid-transfer discards queued descriptors and the in-flight count. tvalid is low the cycle after the reset edge.
- Latency with credit available and IDLE: header_valid in cycle N -> entry visible in N+1 -> pop in N+1 -> tvalid in N+2.
- The back-to-back issue rate is one command per 2 cycles (ISSUE, then IDLE).
- Pulses are registered, one cycle after the causing event, and last exactly 1 cycle.
- When the queue is full and a pop happens in the same cycle as header_valid, the header is accepted and fifo_level stays at FIFO_DEPTH.
- tvalid never deasserts before tready (AXI-Stream rule).

## Structure
- Shared package rdma_rx_pkg holds the opcode constants, the command field positions/widths and the descriptor struct {addr[31:0], btt[22:0]}.
- Sub-module rx_desc_fifo: synchronous FIFO, FIRST-word-fall-through, with push, pop, full, empty and level outputs, and synchronous active-high reset.
- The top level contains the admission logic, the FSM, the tag and outstanding counters, and the status registers.

## Test plan
- Single WRITE_ONLY (8'h0A), addr 0x1000_0000, offset 0x40, length 256, tready tied 1 -> tdata addr 0x1000_0040, btt 256, tag 0 in cycle N+2; a later cmplt -> write_complete, outstanding 1 -> 0.
- Six valid headers on consecutive cycles, tready 0, defaults -> first five accepted (one popped into ISSUE, four queued), sixth gives hdr_dropped; drop_count = 1, fifo_level = 4.
- Opcode 8'h04 -> hdr_rejected; length 0 -> hdr_rejected; length 0x0080_0000 -> hdr_rejected; no tvalid for any of them.
- Credit limit: three queued, no completions -> exactly 2 handshakes, then stall with fifo_level = 1; one cmplt -> third issued with tag 2.
- Simultaneous handshake and cmplt with outstanding 1 -> outstanding stays 1; cmplt with outstanding 0 -> cmplt_error.
- areset asserted while ISSUE is holding tvalid with two entries queued -> next cycle tvalid 0, fifo_level 0, outstanding 0, tag 0.

Source files
------------

// File: rtl/rdma_rx_pkg.sv
// Shared RDMA RX definitions: accepted opcodes, DataMover S2MM command layout
// and the queued write descriptor.
package rdma_rx_pkg;

  localparam logic [7:0] RDMA_OPCODE_WRITE_FIRST  = 8'h06;
  localparam logic [7:0] RDMA_OPCODE_WRITE_MIDDLE = 8'h07;
  localparam logic [7:0] RDMA_OPCODE_WRITE_LAST   = 8'h08;
  localparam logic [7:0] RDMA_OPCODE_WRITE_ONLY   = 8'h0A;
  localparam logic [7:0] RDMA_OPCODE_WRITE_TEST   = 8'h01;

  localparam int CMD_W     = 72;
  localparam int CMD_BTT_W = 23;
  localparam int CMD_EOF   = 23;
  localparam int CMD_DSA   = 30;
  localparam int CMD_TYPE  = 31;
  localparam int CMD_ADDR  = 32;
  localparam int CMD_TAG   = 64;

  typedef struct packed {
    logic [31:0]          addr;
    logic [CMD_BTT_W-1:0] btt;
  } desc_t;

  // {rsvd, tag, addr, type=0 (FIXED=incr), DSA=1, 6'b0, EOF=1, btt}
  function automatic logic [CMD_W-1:0] build_cmd(input logic [3:0] tag, input desc_t d);
    logic [CMD_W-1:0] c;
    c = '0;
    c[CMD_BTT_W-1:0]       = d.btt;
    c[CMD_EOF]             = 1'b1;
    c[CMD_DSA]             = 1'b1;
    c[CMD_TYPE]            = 1'b0;
    c[CMD_ADDR +: 32]      = d.addr;
    c[CMD_TAG +: 4]        = tag;
    return c;
  endfunction

  function automatic logic opcode_ok(input logic [7:0] op);
    return (op == RDMA_OPCODE_WRITE_FIRST)  || (op == RDMA_OPCODE_WRITE_MIDDLE) ||
           (op == RDMA_OPCODE_WRITE_LAST)   || (op == RDMA_OPCODE_WRITE_ONLY)   ||
           (op == RDMA_OPCODE_WRITE_TEST);
  endfunction

endpackage

// File: rtl/rx_desc_fifo.sv
// First-word-fall-through descriptor queue; push while full is allowed only
// together with a pop.
module rx_desc_fifo
  import rdma_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  desc_t                  din_i,
  input  logic                   pop_i,
  output desc_t                  dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);

  desc_t           mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     cnt_q, cnt_d;
  logic            do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    cnt_d = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign level_o = cnt_q;

endmodule

// File: rtl/rx_s2mm_cmd_scheduler.sv
// Admits RDMA WRITE headers into a descriptor queue and issues them as
// DataMover S2MM commands under a credit limit of MAX_OUTSTANDING.
module rx_s2mm_cmd_scheduler
  import rdma_rx_pkg::*;
#(
  parameter int C_ADDR_WIDTH    = 32,
  parameter int C_BTT_WIDTH     = 23,
  parameter int OFFSET_LENGTH   = 16,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        header_valid,
  input  logic [7:0]                  rdma_opcode,
  input  logic [63:0]                 rdma_remote_addr,
  input  logic [31:0]                 rdma_length,
  input  logic [OFFSET_LENGTH-1:0]    fragment_offset,
  output logic [71:0]                 m_axis_s2mm_cmd_tdata,
  output logic                        m_axis_s2mm_cmd_tvalid,
  input  logic                        m_axis_s2mm_cmd_tready,
  input  logic                        s2mm_wr_xfer_cmplt,
  output logic                        write_accepted,
  output logic                        hdr_rejected,
  output logic                        hdr_dropped,
  output logic                        write_complete,
  output logic                        cmplt_error,
  output logic [3:0]                  outstanding,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [15:0]                 drop_count,
  output logic                        busy
);

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  state_t             state_q, state_d;
  logic [CMD_W-1:0]   cmd_q;
  logic [3:0]         tag_q, outst_q, outst_d;
  logic [15:0]        drop_cnt_q;
  logic               acc_q, rej_q, drop_q, wc_q, cerr_q;

  logic               pop, hs, rej, acc, drop, wc, cerr;
  logic               fifo_full, fifo_empty;
  desc_t              hdr_desc, head_desc;
  logic               unused_hi_addr;

  assign unused_hi_addr = ^rdma_remote_addr[63:32];

  assign hdr_desc.addr = rdma_remote_addr[31:0] + 32'(fragment_offset);
  assign hdr_desc.btt  = rdma_length[CMD_BTT_W-1:0];

  assign pop  = (state_q == IDLE) && !fifo_empty && (outst_q < MAX_OUT);
  assign hs   = (state_q == ISSUE) && m_axis_s2mm_cmd_tready;
  assign rej  = header_valid && (!opcode_ok(rdma_opcode) || (rdma_length == '0) ||
                ((rdma_length >> C_BTT_WIDTH) != '0));
  assign acc  = header_valid && !rej && (!fifo_full || pop);
  assign drop = header_valid && !rej && fifo_full && !pop;

  rx_desc_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (aclk),
    .rst     (areset),
    .push_i  (acc),
    .din_i   (hdr_desc),
    .pop_i   (pop),
    .dout_o  (head_desc),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop) state_d = ISSUE;
      ISSUE:   if (m_axis_s2mm_cmd_tready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A handshake and a completion together cancel; the completion is still reported.
  always_comb begin
    outst_d = outst_q;
    wc      = 1'b0;
    cerr    = 1'b0;
    if (s2mm_wr_xfer_cmplt) begin
      if (hs) begin
        wc = 1'b1;
      end else if (outst_q != '0) begin
        outst_d = outst_q - 1'b1;
        wc      = 1'b1;
      end else begin
        cerr = 1'b1;
      end
    end else if (hs) begin
      outst_d = outst_q + 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= IDLE;
      cmd_q      <= '0;
      tag_q      <= '0;
      outst_q    <= '0;
      drop_cnt_q <= '0;
      acc_q      <= 1'b0;
      rej_q      <= 1'b0;
      drop_q     <= 1'b0;
      wc_q       <= 1'b0;
      cerr_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) cmd_q <= build_cmd(tag_q, head_desc);
      if (hs)  tag_q <= tag_q + 1'b1;
      outst_q <= outst_d;
      if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 1'b1;
      acc_q  <= acc;
      rej_q  <= rej;
      drop_q <= drop;
      wc_q   <= wc;
      cerr_q <= cerr;
    end
  end

  assign m_axis_s2mm_cmd_tvalid = (state_q == ISSUE);
  assign m_axis_s2mm_cmd_tdata  = cmd_q;
  assign write_accepted         = acc_q;
  assign hdr_rejected           = rej_q;
  assign hdr_dropped            = drop_q;
  assign write_complete         = wc_q;
  assign cmplt_error            = cerr_q;
  assign outstanding            = outst_q;
  assign drop_count             = drop_cnt_q;
  assign busy = (fifo_level != '0) || (outst_q != '0) || (state_q == ISSUE);

endmodule

// File: tb/tb_rx_s2mm_cmd_scheduler.sv
// Directed bench for rx_s2mm_cmd_scheduler with hand-computed expectations.
module tb_rx_s2mm_cmd_scheduler;

  logic        aclk = 1'b0;
  logic        areset;
  logic        header_valid;
  logic [7:0]  rdma_opcode;
  logic [63:0] rdma_remote_addr;
  logic [31:0] rdma_length;
  logic [15:0] fragment_offset;
  logic [71:0] tdata;
  logic        tvalid, tready;
  logic        cmplt;
  logic        write_accepted, hdr_rejected, hdr_dropped, write_complete, cmplt_error;
  logic [3:0]  outstanding;
  logic [2:0]  fifo_level;
  logic [15:0] drop_count;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 aclk = ~aclk;

  rx_s2mm_cmd_scheduler dut (
    .aclk                   (aclk),
    .areset                 (areset),
    .header_valid           (header_valid),
    .rdma_opcode            (rdma_opcode),
    .rdma_remote_addr       (rdma_remote_addr),
    .rdma_length            (rdma_length),
    .fragment_offset        (fragment_offset),
    .m_axis_s2mm_cmd_tdata  (tdata),
    .m_axis_s2mm_cmd_tvalid (tvalid),
    .m_axis_s2mm_cmd_tready (tready),
    .s2mm_wr_xfer_cmplt     (cmplt),
    .write_accepted         (write_accepted),
    .hdr_rejected           (hdr_rejected),
    .hdr_dropped            (hdr_dropped),
    .write_complete         (write_complete),
    .cmplt_error            (cmplt_error),
    .outstanding            (outstanding),
    .fifo_level             (fifo_level),
    .drop_count             (drop_count),
    .busy                   (busy)
  );

  // Each tick leaves us 1 ns after a rising edge: outputs are settled for the
  // new cycle and inputs set now are sampled at the next edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_hdr(input logic [7:0] op, input logic [31:0] addr,
                         input logic [15:0] off, input logic [31:0] len);
    header_valid     = 1'b1;
    rdma_opcode      = op;
    rdma_remote_addr = {32'hDEAD_BEEF, addr};
    fragment_offset  = off;
    rdma_length      = len;
  endtask

  task automatic clr_hdr();
    header_valid = 1'b0;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    clr_hdr();
    cmplt  = 1'b0;
    tick();
    tick();
    areset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b exp=0", tvalid); end
    total++; if (tdata !== 72'h0) begin bad++; $display("FAIL reset_tdata got=%h exp=0", tdata); end
    total++; if ({write_accepted, hdr_rejected, hdr_dropped, write_complete, cmplt_error} !== 5'b0) begin
      bad++; $display("FAIL reset_pulses got=%b exp=00000",
                      {write_accepted, hdr_rejected, hdr_dropped, write_complete, cmplt_error});
    end
    total++; if ({outstanding, fifo_level, drop_count, busy} !== 24'h0) begin
      bad++; $display("FAIL reset_status got out=%0d lvl=%0d drops=%0d busy=%b exp all 0",
                      outstanding, fifo_level, drop_count, busy);
    end
  endtask

  task automatic test_single();
    do_reset();
    tready = 1'b1;
    set_hdr(8'h0A, 32'h1000_0000, 16'h0040, 32'd256);
    tick();
    clr_hdr();
    total++; if (write_accepted !== 1'b1) begin bad++; $display("FAIL single_accept got=%b exp=1", write_accepted); end
    total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL single_early_tvalid got=%b exp=0", tvalid); end
    tick();
    total++; if (tvalid !== 1'b1) begin bad++; $display("FAIL single_tvalid_n2 got=%b exp=1", tvalid); end
    total++; if (tdata !== 72'h00_1000_0040_4080_0100) begin
      bad++; $display("FAIL single_tdata got=%h exp=00100000404080 0100", tdata);
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
    tick();
    total++; if ({tvalid, outstanding} !== {1'b0, 4'd1}) begin
      bad++; $display("FAIL single_after_hs got tvalid=%b out=%0d exp tvalid=0 out=1", tvalid, outstanding);
    end
    tick();
    cmplt = 1'b1;
    tick();
    cmplt = 1'b0;
    total++; if ({write_complete, outstanding} !== {1'b1, 4'd0}) begin
      bad++; $display("FAIL single_cmplt got wc=%b out=%0d exp wc=1 out=0", write_complete, outstanding);
    end
    tick();
    total++; if ({write_complete, busy} !== 2'b00) begin
      bad++; $display("FAIL single_pulse_width got wc=%b busy=%b exp 0 0", write_complete, busy);
    end
  endtask

  task automatic test_overflow();
    int acc_cnt;
    do_reset();
    tready  = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      set_hdr(8'h06, 32'h2000_0000 + 32'(i*16'h100), 16'h0, 32'd64);
      tick();
      if (write_accepted === 1'b1) acc_cnt++;
    end
    clr_hdr();
    total++; if (acc_cnt != 5) begin bad++; $display("FAIL ovf_accepts got=%0d exp=5", acc_cnt); end
    total++; if ({hdr_dropped, write_accepted} !== 2'b10) begin
      bad++; $display("FAIL ovf_drop_pulse got drop=%b acc=%b exp 1 0", hdr_dropped, write_accepted);
    end
    total++; if (drop_count !== 16'd1) begin bad++; $display("FAIL ovf_drop_count got=%0d exp=1", drop_count); end
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL ovf_level got=%0d exp=4", fifo_level); end
    tick();
    total++; if ({hdr_dropped, tvalid} !== 2'b01) begin
      bad++; $display("FAIL ovf_hold got drop=%b tvalid=%b exp 0 1", hdr_dropped, tvalid);
    end
  endtask

  task automatic test_reject();
    logic [7:0]  ops [3];
    logic [31:0] lens[3];
    ops[0] = 8'h04; lens[0] = 32'd16;
    ops[1] = 8'h0A; lens[1] = 32'd0;
    ops[2] = 8'h07; lens[2] = 32'h0080_0000;
    do_reset();
    tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_hdr(ops[i], 32'h3000_0000, 16'h0, lens[i]);
      tick();
      clr_hdr();
      total++; if ({hdr_rejected, write_accepted} !== 2'b10) begin
        bad++; $display("FAIL reject_%0d got rej=%b acc=%b exp 1 0", i, hdr_rejected, write_accepted);
      end
      tick();
      total++; if ({tvalid, fifo_level} !== 4'b0000) begin
        bad++; $display("FAIL reject_%0d_noissue got tvalid=%b lvl=%0d exp 0 0", i, tvalid, fifo_level);
      end
    end
    tready = 1'b0;
    set_hdr(8'h01, 32'hFFFF_FFF0, 16'h0020, 32'h007F_FFFF);
    tick();
    clr_hdr();
    total++; if (write_accepted !== 1'b1) begin bad++; $display("FAIL max_len_accept got=%b exp=1", write_accepted); end
    tick();
    total++; if (tdata !== 72'h00_0000_0010_40FF_FFFF) begin
      bad++; $display("FAIL max_len_tdata got=%h exp=00000000104 0FFFFFF (addr wrap)", tdata);
    end
  endtask

  task automatic test_credit();
    int hs_cnt;
    bit seen;
    do_reset();
    tready = 1'b1;
    hs_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 3) set_hdr(8'h08, 32'h4000_0000, 16'(i*8), 32'd32);
      else clr_hdr();
      if (tvalid === 1'b1) hs_cnt++;
      tick();
    end
    total++; if (hs_cnt != 2) begin bad++; $display("FAIL credit_handshakes got=%0d exp=2", hs_cnt); end
    total++; if ({fifo_level, outstanding, tvalid} !== {3'd1, 4'd2, 1'b0}) begin
      bad++; $display("FAIL credit_stall got lvl=%0d out=%0d tvalid=%b exp 1 2 0", fifo_level, outstanding, tvalid);
    end
    cmplt = 1'b1;
    tick();
    cmplt = 1'b0;
    total++; if ({write_complete, outstanding} !== {1'b1, 4'd1}) begin
      bad++; $display("FAIL credit_cmplt got wc=%b out=%0d exp 1 1", write_complete, outstanding);
    end
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (tvalid === 1'b1) seen = 1'b1;
      else tick();
    end
    total++; if (!seen) begin bad++; $display("FAIL credit_third_issue got=timeout exp=tvalid"); end
    total++; if (tdata[67:64] !== 4'd2) begin bad++; $display("FAIL credit_tag got=%0d exp=2", tdata[67:64]); end
  endtask

  // Continues from test_credit: third command is presented with outstanding 1.
  task automatic test_simul_cmplt();
    cmplt = 1'b1;
    tick();
    cmplt = 1'b0;
    total++; if ({write_complete, outstanding} !== {1'b1, 4'd1}) begin
      bad++; $display("FAIL simul_hs_cmplt got wc=%b out=%0d exp 1 1", write_complete, outstanding);
    end
    cmplt = 1'b1;
    tick();
    total++; if ({write_complete, outstanding} !== {1'b1, 4'd0}) begin
      bad++; $display("FAIL simul_drain got wc=%b out=%0d exp 1 0", write_complete, outstanding);
    end
    tick();
    cmplt = 1'b0;
    total++; if ({cmplt_error, write_complete, outstanding} !== {2'b10, 4'd0}) begin
      bad++; $display("FAIL cmplt_error got err=%b wc=%b out=%0d exp 1 0 0", cmplt_error, write_complete, outstanding);
    end
  endtask

  task automatic test_midreset();
    bit seen;
    do_reset();
    tready = 1'b1;
    set_hdr(8'h0A, 32'h5000_0000, 16'h0, 32'd8);
    tick();
    clr_hdr();
    tick();
    tick();
    tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_hdr(8'h06, 32'h6000_0000, 16'(i), 32'd4);
      tick();
    end
    clr_hdr();
    total++; if ({tvalid, fifo_level, outstanding} !== {1'b1, 3'd2, 4'd1}) begin
      bad++; $display("FAIL midrst_setup got tvalid=%b lvl=%0d out=%0d exp 1 2 1", tvalid, fifo_level, outstanding);
    end
    areset = 1'b1;
    tick();
    areset = 1'b0;
    total++; if ({tvalid, fifo_level, outstanding, busy} !== {1'b0, 3'd0, 4'd0, 1'b0}) begin
      bad++; $display("FAIL midrst_clear got tvalid=%b lvl=%0d out=%0d busy=%b exp 0 0 0 0",
                      tvalid, fifo_level, outstanding, busy);
    end
    tready = 1'b1;
    set_hdr(8'h0A, 32'h7000_0000, 16'h0, 32'd12);
    tick();
    clr_hdr();
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      if (tvalid === 1'b1) seen = 1'b1;
      else tick();
    end
    total++; if (!seen) begin bad++; $display("FAIL midrst_reissue got=timeout exp=tvalid"); end
    total++; if (tdata !== 72'h00_7000_0000_4080_000C) begin
      bad++; $display("FAIL midrst_tag0 got=%h exp=007000000040 80000C", tdata);
    end
  endtask

  initial begin
    areset = 1'b1; header_valid = 1'b0; rdma_opcode = '0; rdma_remote_addr = '0;
    rdma_length = '0; fragment_offset = '0; tready = 1'b0; cmplt = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_reject();
    test_credit();
    test_simul_cmplt();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
